// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared constants and helpers for the FIFO read controller and its output buffer.
package fifo_rd_ctrl_pkg;

  // Number of words the show-ahead output buffer can hold.
  localparam int BUF_DEPTH = 2;

  // Width of the total-occupancy count.
  // It must hold DEPTH array words plus BUF_DEPTH buffered words, which gives SIZE_ADDR+2 bits.
  function automatic int count_width(input int size_addr);
    return size_addr + 2;
  endfunction

endpackage

// File: rtl/fifo_out_buf.sv
// Two-entry FIFO-ordered capture buffer behind the array read port.
// slot0 is always the head word.
// A capture lands in the first free slot.
// A pop removes slot0 and shifts slot1 into its place.
module fifo_out_buf
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int SIZE_DATA = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_cap_en,
  input  logic [SIZE_DATA-1:0] i_cap_data,
  input  logic                 i_pop,
  output logic [1:0]           o_occ,
  output logic [SIZE_DATA-1:0] o_data
);

  logic [SIZE_DATA-1:0] slot0;
  logic [SIZE_DATA-1:0] slot1;
  logic [1:0]           occ;

  localparam logic [1:0] OCC_FULL = 2'(BUF_DEPTH);

  // Capture and pop can happen in the same cycle; both take effect.
  // The controller never captures into a full buffer unless a pop frees a slot in that same cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      occ   <= '0;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      case ({i_pop, i_cap_en})
        2'b10: begin
          slot0 <= slot1;
          occ   <= occ - 2'd1;
        end
        2'b01: begin
          if (occ == 2'd0) slot0 <= i_cap_data;
          else             slot1 <= i_cap_data;
          occ <= occ + 2'd1;
        end
        2'b11: begin
          if (occ == OCC_FULL) begin
            slot0 <= slot1;
            slot1 <= i_cap_data;
          end else begin
            slot0 <= i_cap_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_occ  = occ;
  assign o_data = slot0;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// FIFO controller that drives a plain storage array.
// It owns the write and read pointers, the array occupancy and the in-flight read flag.
// It decides each cycle whether the array does a read or a write.
// Array reads have one cycle of latency and land in a two-entry show-ahead output buffer.
//
// Handshakes: a transfer happens on a rising clock edge where valid && ready.
// valid never depends on ready from the same side.
// o_wr_ready depends combinationally on i_rd_ready, because a pop can enable a read issue.
module fifo_rd_ctrl
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int SIZE_DATA = 8,
  parameter int SIZE_ADDR = 3
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_wr_valid,
  output logic                   o_wr_ready,
  input  logic [SIZE_DATA-1:0]   i_wr_data,
  output logic                   o_rd_valid,
  input  logic                   i_rd_ready,
  output logic [SIZE_DATA-1:0]   o_rd_data,
  output logic                   o_mem_wr_en,
  output logic [SIZE_ADDR-1:0]   o_mem_wr_addr,
  output logic [SIZE_DATA-1:0]   o_mem_wr_data,
  output logic                   o_mem_rd_en,
  output logic [SIZE_ADDR-1:0]   o_mem_rd_addr,
  input  logic [SIZE_DATA-1:0]   i_mem_rd_data,
  output logic [SIZE_ADDR+1:0]   o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int              DEPTH    = 2 ** SIZE_ADDR;
  localparam int              CW       = count_width(SIZE_ADDR);
  localparam logic [SIZE_ADDR:0] FULL_CNT = (SIZE_ADDR + 1)'(DEPTH);

  logic [SIZE_ADDR-1:0] wr_ptr;
  logic [SIZE_ADDR-1:0] rd_ptr;
  logic [SIZE_ADDR:0]   mem_cnt;
  logic                 inflight;
  logic [1:0]           occ;
  logic [2:0]           buf_load;
  logic                 pop;
  logic                 push;
  logic                 rd_issue;

  // The buffer slots plus the word in flight must still fit after this cycle's pop.
  // The pop term is written on the right-hand side so the unsigned compare cannot underflow.
  assign pop      = o_rd_valid && i_rd_ready;
  assign buf_load = {1'b0, occ} + {2'b00, inflight};
  assign rd_issue = (mem_cnt != '0) && (buf_load < (3'(BUF_DEPTH) + {2'b00, pop}));

  // The array cannot read and write in the same cycle, so a read issue blocks pushes.
  assign o_full     = (mem_cnt == FULL_CNT);
  assign o_wr_ready = !o_full && !rd_issue;
  assign push       = i_wr_valid && o_wr_ready;

  assign o_mem_wr_en   = push;
  assign o_mem_wr_addr = wr_ptr;
  assign o_mem_wr_data = i_wr_data;
  assign o_mem_rd_en   = rd_issue;
  assign o_mem_rd_addr = rd_ptr;

  // Pointer, array-occupancy and in-flight bookkeeping.
  // Pointers wrap through natural binary overflow.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mem_cnt  <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= rd_issue;
      if (rd_issue) begin
        rd_ptr  <= rd_ptr + 1'b1;
        mem_cnt <= mem_cnt - 1'b1;
      end else if (push) begin
        wr_ptr  <= wr_ptr + 1'b1;
        mem_cnt <= mem_cnt + 1'b1;
      end
    end
  end

  // Array read data is captured only when this block issued the read in the previous cycle.
  // Because inflight is cleared on reset, a read result arriving right after reset is dropped.
  fifo_out_buf #(
    .SIZE_DATA (SIZE_DATA)
  ) u_out_buf (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_cap_en   (inflight),
    .i_cap_data (i_mem_rd_data),
    .i_pop      (pop),
    .o_occ      (occ),
    .o_data     (o_rd_data)
  );

  assign o_rd_valid = (occ != 2'd0);
  assign o_count    = CW'(mem_cnt) + CW'(inflight) + CW'(occ);
  assign o_empty    = (o_count == '0);

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl with a behavioural storage array and a scoreboard.
module tb_fifo_rd_ctrl;

  localparam int SIZE_DATA = 8;
  localparam int SIZE_ADDR = 3;

  // ---------------- clock / reset ----------------
  logic                 i_clk;
  logic                 i_rst_n;
  logic                 i_wr_valid;
  logic                 o_wr_ready;
  logic [SIZE_DATA-1:0] i_wr_data;
  logic                 o_rd_valid;
  logic                 i_rd_ready;
  logic [SIZE_DATA-1:0] o_rd_data;
  logic                 o_mem_wr_en;
  logic [SIZE_ADDR-1:0] o_mem_wr_addr;
  logic [SIZE_DATA-1:0] o_mem_wr_data;
  logic                 o_mem_rd_en;
  logic [SIZE_ADDR-1:0] o_mem_rd_addr;
  logic [SIZE_DATA-1:0] i_mem_rd_data;
  logic [SIZE_ADDR+1:0] o_count;
  logic                 o_full;
  logic                 o_empty;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  fifo_rd_ctrl #(
    .SIZE_DATA (SIZE_DATA),
    .SIZE_ADDR (SIZE_ADDR)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_wr_valid    (i_wr_valid),
    .o_wr_ready    (o_wr_ready),
    .i_wr_data     (i_wr_data),
    .o_rd_valid    (o_rd_valid),
    .i_rd_ready    (i_rd_ready),
    .o_rd_data     (o_rd_data),
    .o_mem_wr_en   (o_mem_wr_en),
    .o_mem_wr_addr (o_mem_wr_addr),
    .o_mem_wr_data (o_mem_wr_data),
    .o_mem_rd_en   (o_mem_rd_en),
    .o_mem_rd_addr (o_mem_rd_addr),
    .i_mem_rd_data (i_mem_rd_data),
    .o_count       (o_count),
    .o_full        (o_full),
    .o_empty       (o_empty)
  );

  // Storage array model: 1-cycle read latency; a read is ignored when written in the same cycle.
  logic [SIZE_DATA-1:0] mem [2**SIZE_ADDR];
  logic [SIZE_DATA-1:0] mem_q;
  always @(posedge i_clk) begin
    if (o_mem_wr_en)      mem[o_mem_wr_addr] <= o_mem_wr_data;
    else if (o_mem_rd_en) mem_q <= mem[o_mem_rd_addr];
  end
  assign i_mem_rd_data = mem_q;

  // ---------------- scoreboard state ----------------
  logic [SIZE_DATA-1:0] exp_q[$];
  logic [SIZE_DATA-1:0] exp_w;
  logic [SIZE_ADDR-1:0] m_wr_ptr;
  logic [SIZE_ADDR-1:0] m_rd_ptr;
  int model_cnt;
  int n_checks;
  int n_fail;
  int cyc;
  int acc_cyc;
  int first_valid_cyc;
  int wait_cnt;
  bit slow_mode;
  bit last_wr_fire;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock cycle: called at a negedge; samples 2 units later, then advances to the next negedge.
  task automatic tick();
    bit wr_fire;
    bit rd_fire;
    wr_fire = 1'b0;
    rd_fire = 1'b0;
    #2;
    if (!i_rst_n) begin
      exp_q.delete();
      m_wr_ptr  = '0;
      m_rd_ptr  = '0;
      model_cnt = 0;
      wait_cnt  = 0;
    end else begin
      check_eq("mem_excl", 32'(o_mem_wr_en && o_mem_rd_en), 32'd0);
      check_eq("count", 32'(o_count), 32'(model_cnt));
      check_eq("empty", 32'(o_empty), 32'(model_cnt == 0));
      if (o_mem_rd_en) begin
        check_eq("rd_addr", 32'(o_mem_rd_addr), 32'(m_rd_ptr));
        m_rd_ptr = m_rd_ptr + 1'b1;
      end
      wr_fire = i_wr_valid && o_wr_ready;
      if (wr_fire) begin
        check_eq("wr_en", 32'(o_mem_wr_en), 32'd1);
        check_eq("wr_addr", 32'(o_mem_wr_addr), 32'(m_wr_ptr));
        check_eq("wr_data", 32'(o_mem_wr_data), 32'(i_wr_data));
        exp_q.push_back(i_wr_data);
        m_wr_ptr = m_wr_ptr + 1'b1;
        model_cnt++;
        acc_cyc = cyc;
      end else begin
        check_eq("wr_en_idle", 32'(o_mem_wr_en), 32'd0);
      end
      if (o_rd_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      rd_fire = o_rd_valid && i_rd_ready;
      if (rd_fire) begin
        if (exp_q.size() == 0) begin
          check_eq("rd_unexpected", 32'd1, 32'd0);
        end else begin
          exp_w = exp_q.pop_front();
          check_eq("rd_data", 32'(o_rd_data), 32'(exp_w));
        end
        model_cnt--;
      end
      if (rd_fire)         wait_cnt = 0;
      else if (o_rd_valid) wait_cnt++;
    end
    last_wr_fire = wr_fire;
    cyc++;
    @(negedge i_clk);
    if (slow_mode) i_rd_ready = (wait_cnt >= 2);
  endtask

  task automatic push_word(input logic [SIZE_DATA-1:0] d);
    i_wr_valid = 1'b1;
    i_wr_data  = d;
    for (int n = 0; n < 64; n++) begin
      tick();
      if (last_wr_fire) begin
        i_wr_valid = 1'b0;
        return;
      end
    end
    i_wr_valid = 1'b0;
    check_eq("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    i_rd_ready = 1'b1;
    for (int n = 0; n < 200 && model_cnt != 0; n++) tick();
    check_eq("drain_done", 32'(model_cnt), 32'd0);
    tick();
    i_rd_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail = 0;
    cyc = 0;
    acc_cyc = 0;
    first_valid_cyc = -1;
    wait_cnt = 0;
    slow_mode = 1'b0;
    last_wr_fire = 1'b0;
    model_cnt = 0;
    m_wr_ptr = '0;
    m_rd_ptr = '0;
    i_rst_n = 1'b0;
    i_wr_valid = 1'b0;
    i_wr_data = '0;
    i_rd_ready = 1'b0;
    @(negedge i_clk);
    tick();
    tick();
    i_rst_n = 1'b1;

    // Reset values
    #1;
    check_eq("rst_rd_valid", 32'(o_rd_valid), 32'd0);
    check_eq("rst_rd_data", 32'(o_rd_data), 32'd0);
    check_eq("rst_count", 32'(o_count), 32'd0);
    check_eq("rst_empty", 32'(o_empty), 32'd1);
    check_eq("rst_full", 32'(o_full), 32'd0);
    check_eq("rst_mem_wr_en", 32'(o_mem_wr_en), 32'd0);
    check_eq("rst_mem_rd_en", 32'(o_mem_rd_en), 32'd0);

    // Three pushes with the reader stalled: latency, occupancy and head word
    first_valid_cyc = -1;
    push_word(8'h11);
    check_eq("first_wr_addr_cycle", 32'(acc_cyc), 32'(cyc - 1));
    begin
      int t0;
      t0 = acc_cyc;
      push_word(8'h22);
      push_word(8'h33);
      tick();
      tick();
      check_eq("latency", 32'(first_valid_cyc - t0), 32'd3);
    end
    #1;
    check_eq("t1_count", 32'(o_count), 32'd3);
    check_eq("t1_rd_valid", 32'(o_rd_valid), 32'd1);
    check_eq("t1_head", 32'(o_rd_data), 32'h11);
    drain();

    // Read issue takes priority over a simultaneous push; the push data is held and accepted later
    push_word(8'h5A);
    i_wr_valid = 1'b1;
    i_wr_data  = 8'hA5;
    #1;
    check_eq("prio_rd_en", 32'(o_mem_rd_en), 32'd1);
    check_eq("prio_wr_ready", 32'(o_wr_ready), 32'd0);
    tick();
    #1;
    check_eq("prio_wr_ready2", 32'(o_wr_ready), 32'd1);
    check_eq("prio_wr_data", 32'(o_mem_wr_data), 32'hA5);
    tick();
    i_wr_valid = 1'b0;
    drain();

    // Continuous pushes 0x00..0x0F with the reader always ready
    i_rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) push_word(8'(i));
    drain();

    // Fill to total capacity, then try an 11th push
    for (int i = 0; i < 10; i++) push_word(8'(8'h30 + i));
    tick();
    tick();
    #1;
    check_eq("full_flag", 32'(o_full), 32'd1);
    check_eq("full_wr_ready", 32'(o_wr_ready), 32'd0);
    check_eq("full_count", 32'(o_count), 32'd10);
    i_wr_valid = 1'b1;
    i_wr_data  = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("full_stall", 32'(o_wr_ready), 32'd0);
      check_eq("full_no_write", 32'(o_mem_wr_en), 32'd0);
      tick();
    end
    i_wr_valid = 1'b0;
    // Draining from full pops one word every cycle
    i_rd_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check_eq("thru_valid", 32'(o_rd_valid), 32'd1);
      tick();
    end
    #1;
    check_eq("thru_empty", 32'(o_empty), 32'd1);
    i_rd_ready = 1'b0;

    // 20 random words, each read two cycles after it becomes available; pointers wrap
    slow_mode = 1'b1;
    for (int i = 0; i < 20; i++) push_word(8'($urandom_range(0, 255)));
    for (int n = 0; n < 300 && model_cnt != 0; n++) tick();
    check_eq("slow_drained", 32'(model_cnt), 32'd0);
    slow_mode = 1'b0;
    i_rd_ready = 1'b0;
    tick();

    // Reset while one word is buffered and another read is in flight
    push_word(8'h77);
    push_word(8'h88);
    tick();
    #1;
    check_eq("pre_rst_count", 32'(o_count), 32'd2);
    check_eq("pre_rst_valid", 32'(o_rd_valid), 32'd1);
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    #1;
    check_eq("post_rst_valid", 32'(o_rd_valid), 32'd0);
    check_eq("post_rst_count", 32'(o_count), 32'd0);
    check_eq("post_rst_empty", 32'(o_empty), 32'd1);
    tick();
    tick();
    #1;
    check_eq("post_rst_no_capture", 32'(o_count), 32'd0);
    check_eq("post_rst_valid2", 32'(o_rd_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
